// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: arbiter state encoding, inter-frame gap, RMII width.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package eth_pkg;

    // Arbiter state encoding; the values are visible to the RX/TX paths and debug.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_IFG    = 2'd3
    } arb_state_t;

    // 96 bit times at 2 bits per reference clock.
    localparam int pIFG_CYCLES = 48;

    // Di-bit width of the RMII data path.
    localparam int RMII_WIDTH  = 2;

    // One-hot grant vector for a two-source arbiter.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: chooses which requester wins the next frame.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller samples the result only when it can grant.
//
// Ports:
//   i_req      request bits, bit 0 is source 0
//   i_last     index of the most recently granted source
//   o_winner   index of the chosen source (valid only when o_valid is high)
//   o_valid    at least one source is requesting
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner,
    output logic       o_valid
);

    assign o_valid  = |i_req;
    // On a tie the source that did not go last wins; a lone requester wins outright.
    assign o_winner = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule

// File: rtl/eth_tx_arb.sv
// Shares one RMII TX MAC between two frame sources: round-robin grant, start/done
// handshake, stuck-frame watchdog and inter-frame gap. Grant is 1 cycle after Req.
// Backpressure: a source holds Req until granted; requests are held off outside IDLE.
//
// Ports:
//   i_Clk, i_Rst_N   50 MHz RMII reference clock, asynchronous active-low reset
//   i_Req[1:0]       level request per source
//   o_Grant[1:0]     one-hot grant, held for the whole frame
//   o_Sel            MAC data-mux select (index of the granted source)
//   o_Tx_Start       one-cycle start pulse to the MAC
//   i_Tx_Busy        MAC transmitting; acknowledges the start
//   i_Tx_Done        one-cycle pulse from the MAC after FCS
//   o_Abort          one-cycle pulse when the watchdog expires
//   o_Arb_Busy       high whenever the arbiter is not idle
module eth_tx_arb #(
    parameter int pIFG_CYCLES     = eth_pkg::pIFG_CYCLES,
    parameter int pTIMEOUT_CYCLES = 8192,
    parameter int pTMO_WIDTH      = 13
) (
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic [1:0] i_Req,
    output logic [1:0] o_Grant,
    output logic       o_Sel,
    output logic       o_Tx_Start,
    input  logic       i_Tx_Busy,
    input  logic       i_Tx_Done,
    output logic       o_Abort,
    output logic       o_Arb_Busy
);

    import eth_pkg::*;

    // Both counters restart on state entry, so the terminal values are the only
    // comparisons needed and neither counter can wrap.
    localparam logic [7:0]            LP_IFG_LAST = 8'(pIFG_CYCLES - 1);
    localparam logic [pTMO_WIDTH-1:0] LP_TMO_LAST = pTMO_WIDTH'(pTIMEOUT_CYCLES - 1);
    localparam logic [pTMO_WIDTH-1:0] LP_TMO_ONE  = pTMO_WIDTH'(1);

    arb_state_t            r_state;
    logic                  r_last;
    logic [7:0]            r_ifg_cnt;
    logic [pTMO_WIDTH-1:0] r_wd_cnt;
    logic [1:0]            r_grant;
    logic                  r_sel;
    logic                  r_tx_start;
    logic                  r_abort;
    logic                  r_arb_busy;

    logic                  w_winner;
    logic                  w_win_vld;

    rr_arb2 u_rr_arb2 (
        .i_req    (i_Req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_win_vld)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;     // source 0 wins the first tie
            r_ifg_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_grant    <= 2'b00;
            r_sel      <= 1'b0;
            r_tx_start <= 1'b0;
            r_abort    <= 1'b0;
            r_arb_busy <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            r_tx_start <= 1'b0;
            r_abort    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_grant    <= onehot2(w_winner);
                        r_sel      <= w_winner;
                        r_tx_start <= 1'b1;
                        r_last     <= w_winner;
                        r_wd_cnt   <= '0;
                        r_arb_busy <= 1'b1;
                        r_state    <= ST_START;
                    end
                end

                ST_START, ST_ACTIVE: begin
                    // Frame end takes priority over watchdog expiry in the same cycle.
                    // Tx_Done is also accepted before the MAC has raised Tx_Busy.
                    if (i_Tx_Done) begin
                        r_grant   <= 2'b00;
                        r_ifg_cnt <= '0;
                        r_state   <= ST_IFG;
                    end else if (r_wd_cnt == LP_TMO_LAST) begin
                        r_grant   <= 2'b00;
                        r_abort   <= 1'b1;
                        r_ifg_cnt <= '0;
                        r_state   <= ST_IFG;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + LP_TMO_ONE;
                        if (r_state == ST_START && i_Tx_Busy) begin
                            r_state <= ST_ACTIVE;
                        end
                    end
                end

                ST_IFG: begin
                    if (r_ifg_cnt == LP_IFG_LAST) begin
                        r_arb_busy <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 8'd1;
                    end
                end

                default: begin
                    r_grant    <= 2'b00;
                    r_arb_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Grant    = r_grant;
    assign o_Sel      = r_sel;
    assign o_Tx_Start = r_tx_start;
    assign o_Abort    = r_abort;
    assign o_Arb_Busy = r_arb_busy;

endmodule
